// File: rtl/nn_bp_pkg.sv
// Shared constants, FSM encoding and saturation helper for the output-neuron
// backprop block.
package nn_bp_pkg;
  localparam int NIN = 14;
  localparam int DW  = 17;
  localparam int SW  = DW + 3;
  localparam logic [DW-1:0] ONE_Q16 = 17'h10000;

  typedef enum logic [2:0] {
    S_IDLE, S_DSIG, S_DELTA, S_GAIN, S_UPD, S_DONE
  } state_t;

  // Clamp a widened sum back into the signed 17-bit weight range.
  function automatic logic [DW-1:0] sat17(input logic signed [SW-1:0] v);
    if (v > 20'sd65535)       return {1'b0, {(DW-1){1'b1}}};
    else if (v < -20'sd65536) return {1'b1, {(DW-1){1'b0}}};
    else                      return v[DW-1:0];
  endfunction
endpackage

// File: rtl/neuron_out_backprop_if.sv
// Request/response bundle between the weight store and the backprop block.
interface neuron_out_backprop_if;
  import nn_bp_pkg::*;
  logic                      start;
  logic [NIN-1:0][DW-1:0]    x;
  logic [NIN-1:0][DW-1:0]    w;
  logic [DW-1:0]             y;
  logic [DW-1:0]             target;
  logic [DW-1:0]             eta;
  logic [NIN-1:0][DW-1:0]    w_new;
  logic signed [17:0]        delta;
  logic                      busy;
  logic                      done;

  modport master (output start, x, w, y, target, eta,
                  input  w_new, delta, busy, done);
  modport slave  (input  start, x, w, y, target, eta,
                  output w_new, delta, busy, done);
endinterface

// File: rtl/bp_update_mac.sv
// Combinational weight update: sat17(w + ((g * x) >>> 17)).
module bp_update_mac
  import nn_bp_pkg::*;
(
  input  logic signed [17:0]   g,
  input  logic [DW-1:0]        x,
  input  logic [DW-1:0]        w,
  output logic [DW-1:0]        w_upd
);
  logic signed [35:0]   prod;
  logic signed [SW-1:0] sum;
  logic                 unused_lo;

  assign prod = g * $signed({1'b0, x});
  // |g| <= 32767 keeps the shifted product within 19 bits, so the slice is the floor shift.
  assign sum       = {{3{w[DW-1]}}, w} + {prod[35], prod[35:17]};
  assign unused_lo = ^prod[16:0];
  assign w_upd     = sat17(sum);
endmodule

// File: rtl/neuron_out_backprop.sv
// Iterative backprop for the 14-input output neuron: delta, gain, then one
// weight update per cycle through a single MAC; done pulses for one cycle.
module neuron_out_backprop
  import nn_bp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  neuron_out_backprop_if.slave bus
);
  state_t                 state, state_nxt;
  logic [3:0]             idx;
  logic [NIN-1:0][DW-1:0] x_r, w_r, w_new_r;
  logic [DW-1:0]          y_r, t_r, eta_r, dsig;
  logic signed [17:0]     delta_r, g_r, err, op_a, op_b;
  logic signed [35:0]     prod;
  logic [DW-1:0]          mac_w;
  logic                   unused_prod;
  logic                   last;

  assign err  = $signed({1'b0, t_r}) - $signed({1'b0, y_r});
  assign last = (idx == 4'(NIN - 1));

  // One multiplier serves the three scalar steps ahead of the update loop.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      S_DSIG:  begin op_a = $signed({1'b0, y_r});  op_b = $signed({1'b0, ONE_Q16 - y_r}); end
      S_DELTA: begin op_a = err;                   op_b = $signed({1'b0, dsig});          end
      S_GAIN:  begin op_a = delta_r;               op_b = $signed({1'b0, eta_r});         end
      default: ;
    endcase
  end
  assign prod        = op_a * op_b;
  assign unused_prod = ^{prod[35:34], prod[15:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_DSIG;
      S_DSIG:  state_nxt = S_DELTA;
      S_DELTA: state_nxt = S_GAIN;
      S_GAIN:  state_nxt = S_UPD;
      S_UPD:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  bp_update_mac u_mac (
    .g     (g_r),
    .x     (x_r[idx]),
    .w     (w_r[idx]),
    .w_upd (mac_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      dsig    <= '0;
      delta_r <= '0;
      g_r     <= '0;
      w_new_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_DSIG:  dsig    <= prod[32:16];
        S_DELTA: delta_r <= prod[33:16];
        S_GAIN:  g_r     <= prod[33:16];
        S_UPD: begin
          w_new_r[idx] <= mac_w;
          idx          <= last ? 4'd0 : idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Operands are frozen at accept so the caller may move on immediately.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start && !rst) begin
      x_r   <= bus.x;
      w_r   <= bus.w;
      y_r   <= bus.y;
      t_r   <= bus.target;
      eta_r <= bus.eta;
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.delta = delta_r;
  assign bus.w_new = w_new_r;
endmodule

// File: tb/tb_neuron_out_backprop.sv
// Directed vector table plus hand sequences for handshake, reset abort and input latching.
module tb_neuron_out_backprop;
  import nn_bp_pkg::*;
  localparam int WW = NIN * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_out_backprop_if bus();
  neuron_out_backprop dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [16:0] y, t, eta, xv, wv;
    logic [17:0] exp_delta;
    logic [16:0] exp_w;
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rep(input logic [16:0] v);
    logic [NIN-1:0][DW-1:0] r;
    for (int i = 0; i < NIN; i++) r[i] = v;
    return r;
  endfunction

  task automatic start_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin lat = c; break; end
    end
  endtask

  task automatic drive(input vec_t v);
    bus.y = v.y; bus.target = v.t; bus.eta = v.eta;
    bus.x = rep(v.xv); bus.w = rep(v.wv);
  endtask

  initial begin
    int lat, nd, first_d, last_d;
    bit bok;
    logic [NIN-1:0][DW-1:0] xs, ws, exp_w;

    //        y         target    eta       x         w         delta       w_new
    vecs[0] = '{17'h08000, 17'h10000, 17'h10000, 17'h10000, 17'h00000, 18'd8192,  17'd4096};
    vecs[1] = '{17'h08000, 17'h10000, 17'h10000, 17'h10000, 17'h0FFFF, 18'd8192,  17'h0FFFF};
    vecs[2] = '{17'h08000, 17'h00000, 17'h10000, 17'h10000, 17'h10000, 18'h3E000, 17'h10000};
    vecs[3] = '{17'h08000, 17'h00000, 17'h10000, 17'h00001, 17'd5,     18'h3E000, 17'd4};
    vecs[4] = '{17'h00000, 17'h10000, 17'h10000, 17'h10000, 17'd1234,  18'd0,     17'd1234};
    vecs[5] = '{17'h10000, 17'h00000, 17'h10000, 17'h10000, 17'h1FED4, 18'd0,     17'h1FED4};
    vecs[6] = '{17'h08000, 17'h10000, 17'h00000, 17'h10000, 17'd777,   18'd8192,  17'd777};
    vecs[7] = '{17'h04000, 17'h0C000, 17'h08000, 17'h08000, 17'd100,   18'd6144,  17'd868};
    vecs[8] = '{17'h04000, 17'h00000, 17'h10000, 17'h00003, 17'd0,     18'h3F400, 17'h1FFFF};

    rst = 1'b1;
    bus.start = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  WW'(bus.busy), '0);
    chk("reset_done",  WW'(bus.done), '0);
    chk("reset_delta", WW'($unsigned(bus.delta)), '0);
    chk("reset_w_new", bus.w_new, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      drive(vecs[k]);
      start_run();
      wait_done(lat, bok);
      chk($sformatf("vec%0d_latency", k), WW'(lat), WW'(18));
      chk($sformatf("vec%0d_busy", k), WW'(bok), WW'(1));
      chk($sformatf("vec%0d_delta", k), WW'($unsigned(bus.delta)), WW'(vecs[k].exp_delta));
      chk($sformatf("vec%0d_w_new", k), bus.w_new, rep(vecs[k].exp_w));
      @(negedge clk);
      chk($sformatf("vec%0d_idle", k), WW'({bus.busy, bus.done}), '0);
    end

    // target == y: delta is zero and weights come back untouched
    for (int i = 0; i < NIN; i++) begin
      xs[i] = 17'($urandom_range(0, 65536));
      ws[i] = 17'($urandom);
    end
    bus.y = 17'h06000; bus.target = 17'h06000; bus.eta = 17'h10000;
    bus.x = xs; bus.w = ws;
    start_run();
    wait_done(lat, bok);
    chk("zero_err_delta", WW'($unsigned(bus.delta)), '0);
    chk("zero_err_w_new", bus.w_new, ws);
    @(negedge clk);

    // per-slot x_i = i*4096, w_i = i -> g=8192, dw_i = 256*i; inputs scrambled after accept
    for (int i = 0; i < NIN; i++) begin
      xs[i] = 17'(i * 4096);
      ws[i] = 17'(i);
      exp_w[i] = 17'(257 * i);
    end
    bus.y = 17'h08000; bus.target = 17'h10000; bus.eta = 17'h10000;
    bus.x = xs; bus.w = ws;
    start_run();
    bus.x = rep(17'h10000); bus.w = rep(17'h05555); bus.y = 17'h00000;
    wait_done(lat, bok);
    chk("latch_latency", WW'(lat), WW'(18));
    chk("latch_delta", WW'($unsigned(bus.delta)), WW'(8192));
    chk("latch_w_new", bus.w_new, exp_w);
    @(negedge clk);

    // start held high: one done every 19 cycles
    drive(vecs[0]);
    bus.start = 1'b1;
    nd = 0; first_d = 0; last_d = 0;
    for (int c = 1; c <= 57; c++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (nd == 1) first_d = c;
        last_d = c;
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", WW'(nd), WW'(3));
    chk("held_first_done", WW'(first_d), WW'(18));
    chk("held_last_done",  WW'(last_d), WW'(56));
    @(negedge clk);

    // reset mid-run at c10 aborts without a done pulse
    drive(vecs[0]);
    start_run();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",  WW'(bus.busy), '0);
    chk("abort_done",  WW'(bus.done), '0);
    chk("abort_delta", WW'($unsigned(bus.delta)), '0);
    chk("abort_w_new", bus.w_new, '0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", WW'(nd), '0);

    // a fresh run after the abort completes normally
    drive(vecs[7]);
    start_run();
    wait_done(lat, bok);
    chk("restart_latency", WW'(lat), WW'(18));
    chk("restart_delta", WW'($unsigned(bus.delta)), WW'(6144));
    chk("restart_w_new", bus.w_new, rep(17'd868));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuron_out_backprop.md
Name: neuron_out_backprop

Overview:
- Training-direction partner of the 14-input output neuron. The forward neuron computes y = sigma(sum w_i*x_i); this block runs the error back through that neuron and returns updated weights.
- Computes delta = (target - y) * y * (1 - y), then w_i' = sat(w_i + eta*delta*x_i) for all 14 inputs.
- Iterative datapath with one shared multiply per cycle and a start/done handshake.
- Sits beside the output neuron. The weight store loads its results when done pulses.

Parameters:
- NIN, 14, number of neuron inputs/weights.
- DW, 17, word width of x, w, y, target, eta.

Ports:
- clk  in  1  system clock; one clock; all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- x  in  DW*NIN  packed inputs, slot i = bits [17*(i+1)-1 : 17*i]; unsigned Q1.16 (1.0 = 17'h10000).
- w  in  DW*NIN  packed current weights, same slot layout; signed two's complement.
- y  in  DW  forward neuron output; unsigned Q1.16, range 0..17'h10000.
- target  in  DW  desired output; unsigned Q1.16, range 0..17'h10000.
- eta  in  DW  learning rate; unsigned Q1.16.
- w_new  out  DW*NIN  updated weights, same layout; valid when done=1 and held until the next start.
- delta  out  18  signed error gradient; held like w_new.
- busy  out  1  high while a computation is in progress.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset values: busy=0, done=0, delta=0, w_new=0, FSM=IDLE, index=0.
- Reset asserted in any state returns the block to these values on the next edge and aborts the run; no partial result is flagged.
- Input capture: x, w, y, target and eta are latched on the edge where start is accepted, so they may change afterwards.
- start is ignored while busy=1 and in the DONE cycle.
- FSM states, cycle numbers relative to the start-accept edge (cycle 0):
  - IDLE: start=1 latches inputs and moves to DSIG.
  - DSIG (c1): dsig = (y * (65536 - y)) >> 16, 17-bit unsigned.
  - DELTA (c2): err = target - y (18-bit signed); delta = (err * dsig) >>> 16, 18-bit signed.
  - GAIN (c3): g = (delta * eta) >>> 16, 18-bit signed.
  - UPD (c4..c17): one weight per cycle, index i = 0..13.
    - dw_i = (g * x_i) >>> 17.
    - w_new slot i = sat17(w_i + dw_i).
    - index wraps to 0 on leaving UPD.
  - DONE (c18): done=1 for exactly this cycle, then IDLE.
- busy=1 during c1..c18 inclusive; busy=0 in IDLE. A new start is accepted on the cycle after done, giving a throughput of one update per 19 cycles.
- Arithmetic rules:
  - All right shifts are arithmetic and truncate toward negative infinity; no rounding.
  - sat17 clamps to the range -65536..65535.
  - For legal inputs, err, delta and g need no saturation. Bounds: |delta| <= 16384, |g| <= 32767.
- Edge cases:
  - y=0 or y=17'h10000 gives dsig=0, so delta=0 and w_new=w.
  - eta=0 gives w_new=w.

Decomposition:
- Package nn_bp_pkg holds:
  - NIN, DW, ONE_Q16 = 17'h10000;
  - the FSM state encoding;
  - the sat17 function.
- One sub-module, bp_update_mac: given g, x_i and w_i, it returns the saturated sum. It is combinational, so the registering stays in the parent.

Test Plan:
- y=17'h08000, target=17'h10000, eta=17'h10000, all x=17'h10000, all w=0 -> dsig=16384, delta=8192, every w_new slot=4096. done on cycle 18 after start; busy high c1..c18.
- target=y=17'h06000, random w -> delta=0, w_new==w bit-exact.
- Saturation:
  - w_i=65535 with the case-1 stimulus -> slot stays 65535.
  - y=17'h08000, target=0, w_i=-65536 -> delta=-8192, dw=-4096, slot stays -65536.
- Floor check: y=17'h08000, target=0, eta=17'h10000, x_i=1, w_i=5 -> g=-8192, dw=-1, w_new_i=4 (not 5).
- Handshake and reset:
  - start held high through a run -> exactly one done per 19 cycles.
  - rst asserted at c10 -> next edge busy=0, done=0, delta=0, w_new=0; no done pulse follows.
  - a later start completes normally.
- Input-latch check: change x, w, y after the start edge -> results match the latched values.
